traffic_phase_ctrl: RTL

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

---
 rtl/traffic_phase_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_ctrl.sv
// Traffic phase controller: green/yellow/all-red rotation over NUM_PHASES conflicting approaches.
// Optional pedestrian WALK interval is built only when TRAFFIC_WALK_EN is defined.
//
// state  | meaning
// GREEN  | approach `phase` green, all others red; may extend once on sensor
// YELLOW | approach `phase` yellow, all others red
// ALLRED | clearance, every approach red
// WALK   | pedestrian interval, every approach red, walk_light on
module traffic_phase_ctrl #(
   parameter int NUM_PHASES = 2,
   parameter int CNT_W      = 5,
   parameter int T_GREEN    = 6,
   parameter int T_EXT      = 3,
   parameter int T_YEL      = 2,
   parameter int T_ALLRED   = 1,
   parameter int T_WALK     = 4,
   localparam int PH_W      = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tick,
   input  logic [NUM_PHASES-1:0]   sensor,
   input  logic                    walk,
   output logic [2*NUM_PHASES-1:0] lights,
   output logic                    walk_light,
   output logic [PH_W-1:0]         phase,
   output logic [1:0]              state
);

   typedef enum logic [1:0] {
      ST_GREEN  = 2'd0,
      ST_YELLOW = 2'd1,
      ST_ALLRED = 2'd2,
      ST_WALK   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(T_GREEN - 1);
   localparam logic [CNT_W-1:0] EXT_LAST    = CNT_W'(T_GREEN + T_EXT - 1);
   localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(T_YEL - 1);
   localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(T_ALLRED - 1);
   localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(T_WALK - 1);
   localparam logic [PH_W-1:0]  LAST_PH     = PH_W'(NUM_PHASES - 1);

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [PH_W-1:0]           phase_q, phase_d;
   logic                      ext_q, ext_d;
   logic [2*NUM_PHASES-1:0]   lights_q, lights_d;
   logic [PH_W-1:0]           phase_inc;
   logic                      last_tick;
   logic                      walk_pending;

`ifdef TRAFFIC_WALK_EN
   logic walk_req_q, walk_req_d;
   logic walk_light_q, walk_light_d;
   assign walk_pending = walk_req_q;
   assign walk_light   = walk_light_q;
`else
   logic unused_walk;
   assign unused_walk  = walk;
   assign walk_pending = 1'b0;
   assign walk_light   = 1'b0;
`endif

   assign phase_inc = (phase_q == LAST_PH) ? '0 : phase_q + PH_W'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      phase_d   = phase_q;
      ext_d     = ext_q;
      last_tick = 1'b0;
`ifdef TRAFFIC_WALK_EN
      // a walk press during WALK itself is dropped
      walk_req_d = walk_req_q | (walk && (state_q != ST_WALK));
`endif
      if (tick) begin
         cnt_d = cnt_q + CNT_W'(1);
         case (state_q)
            ST_GREEN: begin
               if (ext_q) begin
                  last_tick = (cnt_q == EXT_LAST);
               end else if (cnt_q == GREEN_LAST) begin
                  if (sensor[phase_q]) ext_d = 1'b1;
                  else                 last_tick = 1'b1;
               end
            end
            ST_YELLOW: last_tick = (cnt_q == YEL_LAST);
            ST_ALLRED: last_tick = (cnt_q == ALLRED_LAST);
            ST_WALK:   last_tick = (cnt_q == WALK_LAST);
            default:   last_tick = 1'b1;
         endcase

         if (last_tick) begin
            cnt_d = '0;
            ext_d = 1'b0;
            case (state_q)
               ST_GREEN:  state_d = ST_YELLOW;
               ST_YELLOW: state_d = ST_ALLRED;
               ST_ALLRED: begin
                  // decision uses the request registered before this cycle
                  if (walk_pending) begin
                     state_d = ST_WALK;
`ifdef TRAFFIC_WALK_EN
                     walk_req_d = 1'b0;
`endif
                  end else begin
                     state_d = ST_GREEN;
                     phase_d = phase_inc;
                  end
               end
               default: begin
                  state_d = ST_GREEN;
                  phase_d = phase_inc;
               end
            endcase
         end
      end

      for (int i = 0; i < NUM_PHASES; i++) begin
         if (PH_W'(i) == phase_d && state_d == ST_GREEN)
            lights_d[2*i +: 2] = 2'd1;
         else if (PH_W'(i) == phase_d && state_d == ST_YELLOW)
            lights_d[2*i +: 2] = 2'd2;
         else
            lights_d[2*i +: 2] = 2'd3;
      end
`ifdef TRAFFIC_WALK_EN
      walk_light_d = (state_d == ST_WALK);
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_ALLRED;
         cnt_q    <= '0;
         phase_q  <= LAST_PH;
         ext_q    <= 1'b0;
         lights_q <= '1;
`ifdef TRAFFIC_WALK_EN
         walk_req_q   <= 1'b0;
         walk_light_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         ext_q    <= ext_d;
         lights_q <= lights_d;
`ifdef TRAFFIC_WALK_EN
         walk_req_q   <= walk_req_d;
         walk_light_q <= walk_light_d;
`endif
      end
   end

   assign lights = lights_q;
   assign phase  = phase_q;
   assign state  = state_q;

endmodule
